sram_rr_arbiter: RTL
====================

Name: sram_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single async-SRAM byte controller (ena/write/busy handshake) between two client FSMs, e.g. a pointer-chase engine and a debug/fill engine.
- Sits between the clients and the SRAM controller. It owns the controller's addr/write/ena/wr_data inputs and returns captured read bytes to the granted client.

Parameters:
- ALEN, 16, address width in bits; matches the SRAM controller address width.
- TIMEOUT, 15, max cycles in ISSUE waiting for mem_busy rise before abort. Used only with the optional feature.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- req0  in  1  port-0 request; held high with we0/addr0/wdata0 stable until ack0.
- we0  in  1  port-0 op: 1 = write, 0 = read.
- addr0  in  ALEN  port-0 byte address.
- wdata0  in  8  port-0 write byte.
- ack0  out  1  one-cycle pulse; port-0 op complete.
- rdata0  out  8  port-0 read byte; valid while ack0=1, held until next port-0 ack.
- err0  out  1  one-cycle pulse with ack0 on timeout abort.
- req1, we1, addr1, wdata1, ack1, rdata1, err1: same as port 0, for port 1.
- mem_addr  out  ALEN  address to controller.
- mem_write  out  1  write select to controller.
- mem_ena  out  1  start strobe to controller.
- mem_wr_data  out  8  write byte; external tristate drives it onto the SRAM dq bus.
- mem_busy  in  1  controller busy (state != IDLE).
- mem_rd_data  in  8  controller latched read byte; valid once mem_busy falls after a read.

Behaviour:
- Reset values: mem_ena=0, mem_write=0, mem_addr=0, mem_wr_data=0, ack0/1=0, err0/1=0, rdata0/1=0, state=IDLE, last=1 (port 0 wins first contention).
- FSM states: IDLE, ISSUE, WAIT, DONE. All outputs are registered.
- IDLE:
  - No grant while mem_busy=1. This covers a controller still completing an op after rst.
  - Requester rules: if exactly one req is high, grant it. If both are high, grant !last.
  - On grant: latch sel, we, addr, wdata into mem_*; set mem_ena=1; go to ISSUE.
- ISSUE: hold mem_ena=1 until mem_busy=1, then mem_ena=0 and go to WAIT.
- WAIT: when mem_busy=0, go to DONE. On a read, capture mem_rd_data into rdata[sel] on this edge.
- DONE: ack[sel]=1 for exactly one cycle; last<=sel; go to IDLE.
- Minimum req-to-ack latency: 3 cycles plus controller busy time. Next grant is no earlier than the cycle after ack.
- A client keeping req high after ack is treated as a new request. It re-arbitrates against the other port.
- Fairness: under continuous contention grants strictly alternate 0,1,0,1. A sole requester gets back-to-back grants.
- mem_addr, mem_write and mem_wr_data are stable from grant through DONE. The controller samples addr continuously, so they must not change mid-op.
- req deasserted mid-op is a client protocol violation. The op still completes and the ack is still issued.
- rst mid-op: FSM to IDLE, mem_ena=0 immediately, no ack or err pulse. The controller's in-flight op finishes on its own; IDLE waits for !mem_busy.
- rst wins over all simultaneous events.

Optional Feature:
- Macro: SRAM_ARB_TIMEOUT_EN.
- Defined:
  - A counter (width ceil(log2(TIMEOUT+1))) clears on entry to ISSUE and increments each ISSUE cycle.
  - If it reaches TIMEOUT with mem_busy still 0: mem_ena=0, go to DONE, pulse ack[sel] and err[sel] together, leave rdata unchanged, update last.
- Undefined: no counter. ISSUE waits indefinitely; err0/err1 are tied to 0.

Test Plan:
- Port-0 read of addr 0x0002, controller model returns 0x04 after 6 busy cycles -> mem_ena high until busy, single ack0 pulse, rdata0=0x04, ack1 never.
- req0 and req1 high together from reset: writes 0x11@0x0010 (port 0) and 0x22@0x0020 (port 1), 4 ops each -> grant order 0,1,0,1,0,1,0,1; model memory holds both bytes; mem_addr stable per op.
- Only req1 high continuously for 5 reads -> 5 consecutive ack1 pulses; no ack0; one IDLE cycle between ops.
- rst asserted while in WAIT with mem_busy=1 for 3 more cycles, req0 high -> no ack; mem_ena=0; no new grant until mem_busy falls; port 0 then granted.
- Back-to-back port-0 write 0xAA@0xFFFF then read 0xFFFF -> ack0 twice; rdata0=0xAA; mem_write=1 then 0.
- SRAM_ARB_TIMEOUT_EN defined, TIMEOUT=15, model never asserts mem_busy -> after 15 ISSUE cycles ack0 and err0 pulse together, mem_ena=0; next pending req1 is then granted normally.

Source files
------------

// File: rtl/sram_rr_arbiter_if.sv
// Bundle of client request/ack lines and SRAM controller strobes for sram_rr_arbiter.
// master = arbiter side, slave = clients plus controller side.
interface sram_rr_arbiter_if #(
   parameter int unsigned ALEN = 16
);
   logic            req0;
   logic            we0;
   logic [ALEN-1:0] addr0;
   logic [7:0]      wdata0;
   logic            ack0;
   logic [7:0]      rdata0;
   logic            err0;

   logic            req1;
   logic            we1;
   logic [ALEN-1:0] addr1;
   logic [7:0]      wdata1;
   logic            ack1;
   logic [7:0]      rdata1;
   logic            err1;

   logic [ALEN-1:0] mem_addr;
   logic            mem_write;
   logic            mem_ena;
   logic [7:0]      mem_wr_data;
   logic            mem_busy;
   logic [7:0]      mem_rd_data;

   modport master (
      input  req0, we0, addr0, wdata0,
      output ack0, rdata0, err0,
      input  req1, we1, addr1, wdata1,
      output ack1, rdata1, err1,
      output mem_addr, mem_write, mem_ena, mem_wr_data,
      input  mem_busy, mem_rd_data
   );

   modport slave (
      output req0, we0, addr0, wdata0,
      input  ack0, rdata0, err0,
      output req1, we1, addr1, wdata1,
      input  ack1, rdata1, err1,
      input  mem_addr, mem_write, mem_ena, mem_wr_data,
      output mem_busy, mem_rd_data
   );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-port round-robin arbiter in front of the async-SRAM byte controller.
// Define SRAM_ARB_TIMEOUT_EN to abort ops whose controller never goes busy (flags err).
module sram_rr_arbiter #(
   parameter int unsigned ALEN = 16
`ifdef SRAM_ARB_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = 15
`endif
) (
   input logic              clk,
   input logic              rst,
   sram_rr_arbiter_if.master bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

   state_e          state_q, state_d;
   logic            sel_q, sel_d;
   logic            last_q, last_d;
   logic [ALEN-1:0] mem_addr_q, mem_addr_d;
   logic            mem_write_q, mem_write_d;
   logic            mem_ena_q, mem_ena_d;
   logic [7:0]      mem_wr_data_q, mem_wr_data_d;
   logic            ack0_q, ack0_d, ack1_q, ack1_d;
   logic            err0_q, err0_d, err1_q, err1_d;
   logic [7:0]      rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   logic grant;
   logic grant_sel;
   logic timeout;

   // A controller still finishing an op (e.g. one started before rst) blocks new grants.
   assign grant = (bus.req0 | bus.req1) & ~bus.mem_busy;

   always_comb begin
      grant_sel = 1'b0;
      case ({bus.req1, bus.req0})
         2'b01:   grant_sel = 1'b0;
         2'b10:   grant_sel = 1'b1;
         2'b11:   grant_sel = ~last_q;
         default: grant_sel = 1'b0;
      endcase
   end

`ifdef SRAM_ARB_TIMEOUT_EN
   localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Zero outside ISSUE, so it is already clear on entry.
   assign cnt_d   = (state_q == StIssue) ? cnt_q + CntW'(1) : '0;
   // Fires on the ISSUE cycle whose increment brings the count to TIMEOUT.
   assign timeout = (cnt_q == CntW'(TIMEOUT - 1)) & ~bus.mem_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (grant) state_d = StIssue;
         end
         StIssue: begin
            if (bus.mem_busy) begin
               state_d = StWait;
            end else if (timeout) begin
               state_d = StDone;
            end
         end
         StWait: begin
            if (!bus.mem_busy) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      sel_d         = sel_q;
      last_d        = last_q;
      mem_addr_d    = mem_addr_q;
      mem_write_d   = mem_write_q;
      mem_ena_d     = mem_ena_q;
      mem_wr_data_d = mem_wr_data_q;
      ack0_d        = 1'b0;
      ack1_d        = 1'b0;
      err0_d        = 1'b0;
      err1_d        = 1'b0;
      rdata0_d      = rdata0_q;
      rdata1_d      = rdata1_q;
      case (state_q)
         StIdle: begin
            if (grant) begin
               sel_d         = grant_sel;
               mem_addr_d    = grant_sel ? bus.addr1 : bus.addr0;
               mem_write_d   = grant_sel ? bus.we1 : bus.we0;
               mem_wr_data_d = grant_sel ? bus.wdata1 : bus.wdata0;
               mem_ena_d     = 1'b1;
            end
         end
         StIssue: begin
            if (bus.mem_busy) begin
               mem_ena_d = 1'b0;
            end else if (timeout) begin
               mem_ena_d = 1'b0;
               ack0_d    = ~sel_q;
               ack1_d    = sel_q;
               err0_d    = ~sel_q;
               err1_d    = sel_q;
            end
         end
         StWait: begin
            if (!bus.mem_busy) begin
               ack0_d = ~sel_q;
               ack1_d = sel_q;
               if (!mem_write_q) begin
                  if (sel_q) begin
                     rdata1_d = bus.mem_rd_data;
                  end else begin
                     rdata0_d = bus.mem_rd_data;
                  end
               end
            end
         end
         StDone: begin
            last_d = sel_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q         <= 1'b0;
         last_q        <= 1'b1;
         mem_addr_q    <= '0;
         mem_write_q   <= 1'b0;
         mem_ena_q     <= 1'b0;
         mem_wr_data_q <= '0;
         ack0_q        <= 1'b0;
         ack1_q        <= 1'b0;
         err0_q        <= 1'b0;
         err1_q        <= 1'b0;
         rdata0_q      <= '0;
         rdata1_q      <= '0;
      end else begin
         sel_q         <= sel_d;
         last_q        <= last_d;
         mem_addr_q    <= mem_addr_d;
         mem_write_q   <= mem_write_d;
         mem_ena_q     <= mem_ena_d;
         mem_wr_data_q <= mem_wr_data_d;
         ack0_q        <= ack0_d;
         ack1_q        <= ack1_d;
         err0_q        <= err0_d;
         err1_q        <= err1_d;
         rdata0_q      <= rdata0_d;
         rdata1_q      <= rdata1_d;
      end
   end

   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_write   = mem_write_q;
   assign bus.mem_ena     = mem_ena_q;
   assign bus.mem_wr_data = mem_wr_data_q;
   assign bus.ack0        = ack0_q;
   assign bus.ack1        = ack1_q;
   assign bus.err0        = err0_q;
   assign bus.err1        = err1_q;
   assign bus.rdata0      = rdata0_q;
   assign bus.rdata1      = rdata1_q;

endmodule
